// File: rtl/regfile_dbg_pkg.sv
// Shared types and width helpers for the regfile debug arbiter.
// Used by the arbiter top and its trace FIFO.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STALL,
    ST_ACCESS,
    ST_RESP
  } dbg_state_e;

  function automatic int trace_w(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int drain_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_debug_arbiter_fifo.sv
// First-word-fall-through trace FIFO with clear and sticky overflow.
// A push into a full FIFO only succeeds when a pop frees a slot that cycle.
module trace_fifo
  import regfile_dbg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 37,
  parameter int CW    = count_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full;
  logic             do_push, do_pop, wr_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop_ready && !empty;
    do_push  = push && (!full || do_pop);
    wr_en    = do_push && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (push && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: validity comes from count_q alone.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_valid = !empty;
  assign pop_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Arbitrates the register file between the processor and a debug port,
// and traces every architectural processor write into a FIFO.
module regfile_debug_arbiter
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int TRACE_DEPTH  = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  proc_ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] proc_ctrl_writeReg,
  input  logic [ADDR_WIDTH-1:0] proc_ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] proc_ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] proc_data_writeReg,
  output logic [DATA_WIDTH-1:0] proc_data_readRegA,
  output logic [DATA_WIDTH-1:0] proc_data_readRegB,
  output logic                  proc_stall,
  output logic                  rf_ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] rf_ctrl_writeReg,
  output logic [ADDR_WIDTH-1:0] rf_ctrl_readRegA,
  output logic [ADDR_WIDTH-1:0] rf_ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] rf_data_writeReg,
  input  logic [DATA_WIDTH-1:0] rf_data_readRegA,
  input  logic [DATA_WIDTH-1:0] rf_data_readRegB,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
  input  logic [DATA_WIDTH-1:0] dbg_req_wdata,
  output logic                  dbg_resp_valid,
  input  logic                  dbg_resp_ready,
  output logic [DATA_WIDTH-1:0] dbg_resp_rdata,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [ADDR_WIDTH-1:0] trace_reg,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic [count_w(TRACE_DEPTH)-1:0] trace_count,
  output logic                  trace_overflow,
  input  logic                  trace_clear
);

  localparam int TW    = trace_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W = drain_w(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  dbg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  trace_push;
  logic [TW-1:0]         trace_head;

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    req_write_d         = req_write_q;
    req_addr_d          = req_addr_q;
    req_wdata_d         = req_wdata_q;
    rdata_d             = rdata_q;
    rf_ctrl_writeEnable = proc_ctrl_writeEnable;
    rf_ctrl_writeReg    = proc_ctrl_writeReg;
    rf_ctrl_readRegA    = proc_ctrl_readRegA;
    rf_ctrl_readRegB    = proc_ctrl_readRegB;
    rf_data_writeReg    = proc_data_writeReg;
    unique case (state_q)
      ST_IDLE: begin
        if (dbg_req_valid) begin
          req_write_d = dbg_req_write;
          req_addr_d  = dbg_req_addr;
          req_wdata_d = dbg_req_wdata;
          cnt_d       = DRAIN_LOAD;
          state_d     = (DRAIN_CYCLES > 0) ? ST_STALL : ST_ACCESS;
        end
      end
      ST_STALL: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else cnt_d = cnt_q - 1'b1;
      end
      ST_ACCESS: begin
        rf_ctrl_readRegA    = req_addr_q;
        rf_ctrl_writeEnable = req_write_q;
        rf_ctrl_writeReg    = req_addr_q;
        rf_data_writeReg    = req_wdata_q;
        rdata_d = req_write_q ? req_wdata_q : rf_data_readRegA;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (dbg_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Nothing may reach the regfile while reset is being applied.
    if (reset) rf_ctrl_writeEnable = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign proc_data_readRegA = rf_data_readRegA;
  assign proc_data_readRegB = rf_data_readRegB;
  assign proc_stall         = (state_q != ST_IDLE);
  assign dbg_req_ready      = (state_q == ST_IDLE);
  assign dbg_resp_valid     = (state_q == ST_RESP);
  assign dbg_resp_rdata     = rdata_q;

  assign trace_push = proc_ctrl_writeEnable
                   && (proc_ctrl_writeReg != '0)
                   && (state_q != ST_ACCESS);

  trace_fifo #(
    .DEPTH(TRACE_DEPTH),
    .WIDTH(TW),
    .CW   (count_w(TRACE_DEPTH))
  ) u_trace (
    .clock    (clock),
    .reset    (reset),
    .clear    (trace_clear),
    .push     (trace_push),
    .push_data({proc_ctrl_writeReg, proc_data_writeReg}),
    .pop_ready(trace_ready),
    .pop_valid(trace_valid),
    .pop_data (trace_head),
    .count    (trace_count),
    .overflow (trace_overflow)
  );

  assign trace_reg  = trace_head[TW-1 -: ADDR_WIDTH];
  assign trace_data = trace_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Bench for regfile_debug_arbiter: table vectors, corner sequences and a
// randomized run against a timeline/queue reference model.
module tb_regfile_debug_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DRAIN = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          p_we;
  logic [AW-1:0] p_wreg, p_ra, p_rb;
  logic [DW-1:0] p_wdata;
  logic          t_ready, t_clear;

  logic [DW-1:0] d3_a, d3_b, d3_rfwd, d3_rfa, d3_rfb;
  logic          d3_stall, d3_rfwe;
  logic [AW-1:0] d3_rfwr, d3_rfra, d3_rfrb;
  logic          q3_valid, q3_ready, q3_write;
  logic [AW-1:0] q3_addr;
  logic [DW-1:0] q3_wdata;
  logic          r3_valid, r3_ready;
  logic [DW-1:0] r3_rdata;
  logic          t3_valid, t3_ovf;
  logic [AW-1:0] t3_reg;
  logic [DW-1:0] t3_data;
  logic [CW-1:0] t3_count;

  logic [DW-1:0] d0_a, d0_b, d0_rfwd, d0_rfa, d0_rfb;
  logic          d0_stall, d0_rfwe;
  logic [AW-1:0] d0_rfwr, d0_rfra, d0_rfrb;
  logic          q0_valid, q0_ready, q0_write;
  logic [AW-1:0] q0_addr;
  logic [DW-1:0] q0_wdata;
  logic          r0_valid, r0_ready;
  logic [DW-1:0] r0_rdata;
  logic          t0_valid, t0_ovf;
  logic [AW-1:0] t0_reg;
  logic [DW-1:0] t0_data;
  logic [CW-1:0] t0_count;

  logic [DW-1:0] rf3 [32] = '{default: '0};
  logic [DW-1:0] rf0 [32] = '{default: '0};

  assign d3_rfa = rf3[d3_rfra];
  assign d3_rfb = rf3[d3_rfrb];
  assign d0_rfa = rf0[d0_rfra];
  assign d0_rfb = rf0[d0_rfrb];

  always @(posedge clock) begin
    if (d3_rfwe && d3_rfwr != '0) rf3[d3_rfwr] <= d3_rfwd;
    if (d0_rfwe && d0_rfwr != '0) rf0[d0_rfwr] <= d0_rfwd;
  end

  regfile_debug_arbiter #(.DRAIN_CYCLES(DRAIN)) u_dut3 (
    .clock(clock), .reset(reset),
    .proc_ctrl_writeEnable(p_we), .proc_ctrl_writeReg(p_wreg),
    .proc_ctrl_readRegA(p_ra), .proc_ctrl_readRegB(p_rb),
    .proc_data_writeReg(p_wdata),
    .proc_data_readRegA(d3_a), .proc_data_readRegB(d3_b),
    .proc_stall(d3_stall),
    .rf_ctrl_writeEnable(d3_rfwe), .rf_ctrl_writeReg(d3_rfwr),
    .rf_ctrl_readRegA(d3_rfra), .rf_ctrl_readRegB(d3_rfrb),
    .rf_data_writeReg(d3_rfwd),
    .rf_data_readRegA(d3_rfa), .rf_data_readRegB(d3_rfb),
    .dbg_req_valid(q3_valid), .dbg_req_ready(q3_ready),
    .dbg_req_write(q3_write), .dbg_req_addr(q3_addr),
    .dbg_req_wdata(q3_wdata),
    .dbg_resp_valid(r3_valid), .dbg_resp_ready(r3_ready),
    .dbg_resp_rdata(r3_rdata),
    .trace_valid(t3_valid), .trace_ready(t_ready),
    .trace_reg(t3_reg), .trace_data(t3_data),
    .trace_count(t3_count), .trace_overflow(t3_ovf),
    .trace_clear(t_clear)
  );

  regfile_debug_arbiter #(.DRAIN_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .proc_ctrl_writeEnable(p_we), .proc_ctrl_writeReg(p_wreg),
    .proc_ctrl_readRegA(p_ra), .proc_ctrl_readRegB(p_rb),
    .proc_data_writeReg(p_wdata),
    .proc_data_readRegA(d0_a), .proc_data_readRegB(d0_b),
    .proc_stall(d0_stall),
    .rf_ctrl_writeEnable(d0_rfwe), .rf_ctrl_writeReg(d0_rfwr),
    .rf_ctrl_readRegA(d0_rfra), .rf_ctrl_readRegB(d0_rfrb),
    .rf_data_writeReg(d0_rfwd),
    .rf_data_readRegA(d0_rfa), .rf_data_readRegB(d0_rfb),
    .dbg_req_valid(q0_valid), .dbg_req_ready(q0_ready),
    .dbg_req_write(q0_write), .dbg_req_addr(q0_addr),
    .dbg_req_wdata(q0_wdata),
    .dbg_resp_valid(r0_valid), .dbg_resp_ready(r0_ready),
    .dbg_resp_rdata(r0_rdata),
    .trace_valid(t0_valid), .trace_ready(t_ready),
    .trace_reg(t0_reg), .trace_data(t0_data),
    .trace_count(t0_count), .trace_overflow(t0_ovf),
    .trace_clear(t_clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic quiet();
    p_we = 1'b0; q3_valid = 1'b0; q0_valid = 1'b0;
    r3_ready = 1'b0; r0_ready = 1'b0;
    t_ready = 1'b0; t_clear = 1'b0;
  endtask

  task automatic clear_trace();
    @(negedge clock); quiet(); t_clear = 1'b1;
    @(negedge clock); t_clear = 1'b0;
  endtask

  task automatic pwrite(input logic [AW-1:0] r, input logic [DW-1:0] d);
    @(negedge clock); quiet();
    p_we = 1'b1; p_wreg = r; p_wdata = d;
  endtask

  // Reference model: trace as a queue, regfile as an array, debug
  // transaction as a timeline measured from its accept edge.
  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } tent_t;

  tent_t         tq[$];
  bit            m_ovf;
  logic [DW-1:0] m_rf [32] = '{default: '0};
  bit            m_busy;
  int            m_age;
  bit            m_w;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd, m_resp;

  task automatic model_cycle(input bit rnd);
    bit acc, rsp, pop, push, full;
    @(negedge clock);
    if (rnd) begin
      p_we     = ($urandom_range(0, 2) != 0);
      p_wreg   = AW'($urandom);
      p_wdata  = $urandom;
      p_ra     = AW'($urandom);
      p_rb     = AW'($urandom);
      t_ready  = ($urandom_range(0, 3) == 0);
      t_clear  = ($urandom_range(0, 63) == 0);
      r3_ready = 1'($urandom_range(0, 1));
      q3_write = 1'($urandom_range(0, 1));
      q3_addr  = AW'($urandom);
      q3_wdata = $urandom;
      q3_valid = !m_busy && ($urandom_range(0, 3) == 0);
    end else begin
      quiet();
      r3_ready = 1'b1;
    end
    #1;
    acc = m_busy && (m_age == DRAIN + 1);
    rsp = m_busy && (m_age >= DRAIN + 2);
    chk("rnd_stall", d3_stall, m_busy);
    chk("rnd_req_ready", q3_ready, !m_busy);
    chk("rnd_resp_valid", r3_valid, rsp);
    if (rsp) chk("rnd_resp_rdata", r3_rdata, m_resp);
    chk("rnd_trace_count", t3_count, tq.size());
    chk("rnd_trace_ovf", t3_ovf, m_ovf);
    chk("rnd_trace_valid", t3_valid, tq.size() != 0);
    if (tq.size() != 0) chk("rnd_trace_head", {t3_reg, t3_data}, tq[0]);
    chk("rnd_rd_a", d3_a, m_rf[acc ? m_a : p_ra]);
    chk("rnd_rd_b", d3_b, m_rf[p_rb]);
    if (acc) begin
      if (m_w) begin
        if (m_a != '0) m_rf[m_a] = m_wd;
        m_resp = m_wd;
      end else begin
        m_resp = m_rf[m_a];
      end
    end else if (p_we && p_wreg != '0) begin
      m_rf[p_wreg] = p_wdata;
    end
    push = !acc && p_we && (p_wreg != '0);
    if (t_clear) begin
      tq.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = t_ready && (tq.size() > 0);
      full = (tq.size() == DEPTH);
      if (pop) void'(tq.pop_front());
      if (push) begin
        if (full && !pop) m_ovf = 1'b1;
        else tq.push_back({p_wreg, p_wdata});
      end
    end
    if (!m_busy) begin
      if (q3_valid) begin
        m_busy = 1'b1; m_age = 1;
        m_w = q3_write; m_a = q3_addr; m_wd = q3_wdata;
      end
    end else if (rsp && r3_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [CW-1:0] exp_count;
    logic [AW-1:0] exp_head;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    quiet();
    p_wreg = '0; p_wdata = '0; p_ra = '0; p_rb = '0;
    q3_write = 1'b0; q3_addr = '0; q3_wdata = '0;
    q0_write = 1'b0; q0_addr = '0; q0_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", q3_ready, 1);
    chk("rst_stall", d3_stall, 0);
    chk("rst_resp_valid", r3_valid, 0);
    chk("rst_resp_rdata", r3_rdata, 0);
    chk("rst_trace_valid", t3_valid, 0);
    chk("rst_trace_count", t3_count, 0);
    chk("rst_trace_ovf", t3_ovf, 0);

    for (int i = 0; i < 3000; i++) model_cycle(1'b1);
    for (int i = 0; i < 12; i++) model_cycle(1'b0);
    clear_trace();

    tbl[0] = '{1'b1, 5'd3,  32'h33, 4'd1, 5'd3};
    tbl[1] = '{1'b0, 5'd4,  32'h44, 4'd1, 5'd3};
    tbl[2] = '{1'b1, 5'd0,  32'h55, 4'd1, 5'd3};
    tbl[3] = '{1'b1, 5'd31, 32'hAA, 4'd2, 5'd3};
    tbl[4] = '{1'b1, 5'd3,  32'h77, 4'd3, 5'd3};
    tbl[5] = '{1'b0, 5'd0,  32'h00, 4'd3, 5'd3};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); quiet();
      p_we = tbl[i].we; p_wreg = tbl[i].wreg; p_wdata = tbl[i].wdata;
      #1;
      chk("tbl_fwd_we", d3_rfwe, tbl[i].we);
      chk("tbl_fwd_reg", d3_rfwr, tbl[i].wreg);
      chk("tbl_fwd_data", d3_rfwd, tbl[i].wdata);
      @(negedge clock); quiet();
      #1;
      chk("tbl_count", t3_count, tbl[i].exp_count);
      chk("tbl_head", t3_reg, tbl[i].exp_head);
    end
    chk("tbl_head_data", t3_data, 32'h33);

    // Debug read, 3 drain cycles
    pwrite(5, 32'h1234);
    clear_trace();
    @(negedge clock); quiet();
    q3_valid = 1'b1; q3_write = 1'b0; q3_addr = 5; q3_wdata = '0;
    #1;
    chk("rd_accept_ready", q3_ready, 1);
    chk("rd_accept_stall", d3_stall, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock); q3_valid = 1'b0;
      #1;
      chk("rd_stall", d3_stall, 1);
      chk("rd_resp_valid", r3_valid, k == 5);
      if (k == 4) begin
        chk("rd_access_addr", d3_rfra, 5);
        chk("rd_access_we", d3_rfwe, 0);
      end
      if (k == 5) begin
        chk("rd_rdata", r3_rdata, 32'h1234);
        r3_ready = 1'b1;
      end
    end
    @(negedge clock); r3_ready = 1'b0;
    #1;
    chk("rd_after_stall", d3_stall, 0);
    chk("rd_after_valid", r3_valid, 0);
    chk("rd_after_ready", q3_ready, 1);

    // Debug write colliding with a processor write in ACCESS
    q3_valid = 1'b1; q3_write = 1'b1; q3_addr = 7; q3_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock); q3_valid = 1'b0; p_we = 1'b0;
      if (k == 4) begin
        p_we = 1'b1; p_wreg = 7; p_wdata = 32'h0BAD0BAD;
        #1;
        chk("wr_access_we", d3_rfwe, 1);
        chk("wr_access_reg", d3_rfwr, 7);
        chk("wr_access_data", d3_rfwd, 32'hDEADBEEF);
      end
      if (k == 5) begin
        #1;
        chk("wr_resp_valid", r3_valid, 1);
        chk("wr_resp_rdata", r3_rdata, 32'hDEADBEEF);
        r3_ready = 1'b1;
      end
    end
    @(negedge clock); quiet(); p_ra = 7;
    #1;
    chk("wr_r7", d3_a, 32'hDEADBEEF);
    chk("wr_not_traced", t3_count, 0);

    // Overflow: nine writes into eight slots
    clear_trace();
    for (int i = 1; i <= 9; i++) pwrite(AW'(i), DW'(i));
    @(negedge clock); quiet();
    #1;
    chk("ovf_count", t3_count, 8);
    chk("ovf_flag", t3_ovf, 1);
    for (int i = 1; i <= 8; i++) begin
      t_ready = 1'b1;
      #1;
      chk("ovf_pop_valid", t3_valid, 1);
      chk("ovf_pop_reg", t3_reg, i);
      chk("ovf_pop_data", t3_data, i);
      @(negedge clock);
    end
    t_ready = 1'b0;
    #1;
    chk("ovf_drained", t3_count, 0);
    chk("ovf_drained_valid", t3_valid, 0);
    chk("ovf_sticky", t3_ovf, 1);

    // Full FIFO: r0 write ignored, push+pop keeps count
    clear_trace();
    for (int i = 1; i <= 8; i++) pwrite(AW'(i), DW'(32'h100 + i));
    pwrite(0, 32'hFF);
    @(negedge clock); quiet();
    #1;
    chk("full_r0_count", t3_count, 8);
    chk("full_r0_ovf", t3_ovf, 0);
    p_we = 1'b1; p_wreg = 10; p_wdata = 32'hA; t_ready = 1'b1;
    @(negedge clock); quiet();
    #1;
    chk("full_pp_count", t3_count, 8);
    chk("full_pp_ovf", t3_ovf, 0);
    for (int i = 0; i < 8; i++) begin
      t_ready = 1'b1;
      #1;
      chk("full_pp_reg", t3_reg, (i == 7) ? 10 : i + 2);
      if (i == 7) chk("full_pp_data", t3_data, 32'hA);
      @(negedge clock);
    end
    t_ready = 1'b0;

    // Zero drain with response backpressure
    @(negedge clock); quiet();
    q0_valid = 1'b1; q0_write = 1'b1; q0_addr = 9; q0_wdata = 32'h5A5A5A5A;
    #1;
    chk("z_accept_ready", q0_ready, 1);
    @(negedge clock); q0_valid = 1'b0;
    #1;
    chk("z_access_stall", d0_stall, 1);
    chk("z_access_valid", r0_valid, 0);
    chk("z_access_we", d0_rfwe, 1);
    chk("z_access_reg", d0_rfwr, 9);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clock);
      #1;
      chk("z_hold_valid", r0_valid, 1);
      chk("z_hold_stall", d0_stall, 1);
      chk("z_hold_rdata", r0_rdata, 32'h5A5A5A5A);
    end
    @(negedge clock); r0_ready = 1'b1;
    #1;
    chk("z_hs_valid", r0_valid, 1);
    @(negedge clock); r0_ready = 1'b0;
    #1;
    chk("z_after_valid", r0_valid, 0);
    chk("z_after_stall", d0_stall, 0);
    q0_valid = 1'b1; q0_write = 1'b0; q0_addr = 9;
    @(negedge clock); q0_valid = 1'b0;
    @(negedge clock);
    #1;
    chk("z_rd_valid", r0_valid, 1);
    chk("z_rd_rdata", r0_rdata, 32'h5A5A5A5A);
    r0_ready = 1'b1;
    @(negedge clock); r0_ready = 1'b0;

    // Reset while stalled with three trace entries
    clear_trace();
    for (int i = 1; i <= 3; i++) pwrite(AW'(i), DW'(i));
    @(negedge clock); quiet();
    q3_valid = 1'b1; q3_write = 1'b0; q3_addr = 1;
    @(negedge clock); q3_valid = 1'b0;
    #1;
    chk("mid_stall", d3_stall, 1);
    chk("mid_count", t3_count, 3);
    reset = 1'b1;
    p_we = 1'b1; p_wreg = 4; p_wdata = 32'hBAD;
    #1;
    chk("mid_rst_no_write", d3_rfwe, 0);
    @(negedge clock); reset = 1'b0; quiet(); p_ra = 4;
    #1;
    chk("mid_ready", q3_ready, 1);
    chk("mid_stall_low", d3_stall, 0);
    chk("mid_resp_valid", r3_valid, 0);
    chk("mid_count_zero", t3_count, 0);
    chk("mid_trace_valid", t3_valid, 0);
    chk("mid_r4_kept", d3_a, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_debug_arbiter.md
# regfile_debug_arbiter

Parametrised arbiter between the processor and the register file. It replaces the static test-select muxing with a handshaked debug port that stalls the processor, drains it, performs one read or write, and returns a response. It also records every architectural register write from the processor into a trace FIFO that a bench or debug host can pop. It sits between `processor` and `regfile` inside the test top level.

## Interface
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register index width
- `TRACE_DEPTH`, 8, trace FIFO entries; power of two, ≥2
- `DRAIN_CYCLES`, 3, stall cycles before debug access; 0 allowed

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `proc_ctrl_writeEnable`, `proc_ctrl_writeReg`, `proc_ctrl_readRegA`, `proc_ctrl_readRegB`, `proc_data_writeReg` in 1/AW/AW/AW/DW: processor regfile requests
- `proc_data_readRegA`, `proc_data_readRegB` out DW: read data returned to the processor
- `proc_stall` out 1: freezes the processor PC/pipeline
- `rf_ctrl_writeEnable`, `rf_ctrl_writeReg`, `rf_ctrl_readRegA`, `rf_ctrl_readRegB`, `rf_data_writeReg` out: regfile controls
- `rf_data_readRegA`, `rf_data_readRegB` in DW: regfile read data (combinational)
- `dbg_req_valid` in 1 / `dbg_req_ready` out 1 / `dbg_req_write` in 1 / `dbg_req_addr` in AW / `dbg_req_wdata` in DW: debug request
- `dbg_resp_valid` out 1 / `dbg_resp_ready` in 1 / `dbg_resp_rdata` out DW: debug response
- `trace_valid` out 1 / `trace_ready` in 1 / `trace_reg` out AW / `trace_data` out DW: trace head
- `trace_count` out clog2(TRACE_DEPTH+1): occupancy
- `trace_overflow` out 1: sticky drop flag
- `trace_clear` in 1: empties the FIFO and clears `trace_overflow`

## Operation
- **FSM states:** IDLE, STALL, ACCESS, RESP.
- **IDLE:**
  - `dbg_req_ready` is 1.
  - Accept on `valid&ready`; latch write/addr/wdata.
  - Next state: STALL if DRAIN_CYCLES>0, else ACCESS.
- **STALL:**
  - Counter loads DRAIN_CYCLES-1 and decrements.
  - At 0, go to ACCESS.
  - Processor signals are still forwarded so in-flight writes complete.
- **ACCESS (exactly 1 cycle):**
  - `rf_ctrl_readRegA`=latched addr.
  - For a write: `rf_ctrl_writeEnable`=1, `rf_ctrl_writeReg`=addr, `rf_data_writeReg`=wdata.
  - For a read: `rf_ctrl_writeEnable`=0, and `rf_data_readRegA` is registered into `dbg_resp_rdata`.
  - Processor writes are masked.
  - Next state: RESP.
- **RESP:**
  - `dbg_resp_valid`=1 until `dbg_resp_ready`, then IDLE.
  - For writes, `dbg_resp_rdata` holds the written wdata.
- **`proc_stall`:** 1 in STALL, ACCESS and RESP; 0 in IDLE.
- **Ownership:** outside ACCESS, `rf_*` = `proc_*`, and `proc_data_readRegX` = `rf_data_readRegX` in all states.
- **Register 0:** writes to r0 are issued; the regfile discards them.
- **Trace push:** when a forwarded processor write occurs with `proc_ctrl_writeEnable`=1 and writeReg≠0, push {writeReg, data}.
  - Debug writes are not traced.
- **Trace pop:** on `trace_valid&trace_ready`.
- **Full FIFO:** a push with no pop is dropped and sets `trace_overflow`. Push and pop together while full both succeed and count is unchanged.
- **Empty FIFO:** a pop is ignored.
- **`trace_clear`:** pointers go to 0, count to 0, overflow to 0. It overrides a same-cycle push.

## Timing
- **Reset values:** state IDLE; `proc_stall`=0; `dbg_req_ready`=1 (combinational from IDLE, so 1 after reset); `dbg_resp_valid`=0; `dbg_resp_rdata`=0; `trace_valid`=0; `trace_count`=0; `trace_overflow`=0.
- **Accept-to-response latency:** request accepted at edge T → `proc_stall`=1 from T+1 → ACCESS in cycle T+1+DRAIN_CYCLES → `dbg_resp_valid` from T+2+DRAIN_CYCLES.
- **Back-to-back requests:** the next request can be accepted one cycle after the response handshake.
- **Trace latency:** an entry is visible on `trace_valid` the cycle after the push edge. `trace_*` outputs are registered (FWFT).
- **Reset mid-operation:** abort to IDLE, drop the pending response, deassert the stall, empty the FIFO. No regfile write is issued in the reset cycle.
- **Requester rule:** `dbg_req_*` must be held stable while `dbg_req_valid`=1 and `dbg_req_ready`=0.

## Structure
- **Shared package `regfile_dbg_pkg`:** the FSM state enum, the trace entry width (ADDR_WIDTH+DATA_WIDTH), and helpers for the `trace_count` width.
- **Sub-module `trace_fifo`:** parametrised depth/width, valid/ready pop, push, clear, count and overflow flag.
- **Top module:** holds the FSM, drain counter, request latch and output muxing.

## Test plan
- **Debug read:** DRAIN_CYCLES=3, r5=0x1234 preloaded, debug read addr 5 accepted at T → `proc_stall` high T+1..T+5, `dbg_resp_valid` at T+5 with rdata 0x00001234, stall low after the resp handshake.
- **Debug write:** debug write r7=0xDEADBEEF while the processor attempts a write to r7 in the ACCESS cycle → r7 reads 0xDEADBEEF, nothing traced.
- **Trace overflow:** processor writes r1..r9 (data=index) with no pops, DEPTH=8 → count 8, `trace_overflow`=1, pops return r1..r8 in order.
- **Full push/pop, r0 filter:** full FIFO with simultaneous push r10 and pop → count stays 8, last entry is r10. A write to r0 is not traced.
- **Zero drain, response backpressure:** DRAIN_CYCLES=0, `dbg_resp_ready` held low 4 cycles → ACCESS at T+1, valid from T+2 held stable with the stall held until ready.
- **Reset mid-operation:** reset asserted in STALL with 3 trace entries → next cycle IDLE, `proc_stall`=0, `dbg_resp_valid`=0, `trace_count`=0.
